// File: rtl/conf_uart_tx.sv
// ----------------------------------------------------------------------------
// conf_uart_tx
// Sends a packet of configuration parameters over one UART line. This is the
// frame format the controller's config receiver expects: a start bit (0),
// 8 data bits MSB first, and a stop bit (1). Frames follow each other with no
// gap. All parameters are latched into a shadow register when the packet is
// accepted, so changes on the input during a packet have no effect.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous, active-high reset
//   i_start      packet request, sampled only while idle (including the done cycle)
//   i_par_in     packed parameters; slice [PAR_NUM-1] is sent first
//   o_uart_data  registered serial line, idle high
//   o_busy       high for the whole packet
//   o_done       one-cycle pulse on the first idle cycle after the last stop bit
// ----------------------------------------------------------------------------
module conf_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PAR_NUM      = 6,
   parameter int unsigned PAR_WIDTH    = 8
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_start,
   input  logic [PAR_NUM*PAR_WIDTH-1:0]   i_par_in,
   output logic                           o_uart_data,
   output logic                           o_busy,
   output logic                           o_done
);

   localparam int unsigned PKT_W  = PAR_NUM * PAR_WIDTH;
   localparam int unsigned CLK_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BYTE_W = (PAR_NUM      > 1) ? $clog2(PAR_NUM)      : 1;
   localparam int unsigned BIT_W  = (PAR_WIDTH    > 1) ? $clog2(PAR_WIDTH)    : 1;

   localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PAR_NUM - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAR_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               r_state;
   logic [PKT_W-1:0]     r_shadow;
   logic [CLK_W-1:0]     r_clk_cnt;
   logic [BYTE_W-1:0]    r_byte_cnt;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic                 r_uart_data;
   logic                 r_busy;
   logic                 r_done;

   logic [PAR_WIDTH-1:0] w_cur_par;
   logic [BIT_W-1:0]     w_bit_prev;
   logic                 w_bit_end;

   // Byte 0 of the packet is the most significant slice of the shadow register
   always_comb begin
      w_cur_par = '0;
      for (int i = 0; i < int'(PAR_NUM); i++) begin
         if (r_byte_cnt == BYTE_W'(i)) begin
            w_cur_par = r_shadow[(int'(PAR_NUM) - 1 - i) * int'(PAR_WIDTH) +: PAR_WIDTH];
         end
      end
   end

   assign w_bit_end  = (r_clk_cnt == CLK_LAST);
   assign w_bit_prev = r_bit_cnt - BIT_W'(1);

   // Frame sequencer; the line value for the next bit is registered on the
   // same edge as the state change, so the line has no glitches.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_shadow    <= '0;
         r_clk_cnt   <= '0;
         r_byte_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_uart_data <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_uart_data <= 1'b1;
               r_busy      <= 1'b0;
               r_clk_cnt   <= '0;
               if (i_start) begin
                  r_shadow    <= i_par_in;
                  r_byte_cnt  <= '0;
                  r_bit_cnt   <= '0;
                  r_state     <= S_START;
                  r_uart_data <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_clk_cnt   <= '0;
                  r_bit_cnt   <= BIT_LAST;
                  r_state     <= S_DATA;
                  r_uart_data <= w_cur_par[BIT_LAST];
               end else begin
                  r_clk_cnt <= r_clk_cnt + CLK_W'(1);
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_bit_cnt == '0) begin
                     r_state     <= S_STOP;
                     r_uart_data <= 1'b1;
                  end else begin
                     r_bit_cnt   <= w_bit_prev;
                     r_uart_data <= w_cur_par[w_bit_prev];
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CLK_W'(1);
               end
            end

            S_STOP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_byte_cnt < BYTE_LAST) begin
                     // Next frame starts immediately, with no idle bits in between
                     r_byte_cnt  <= r_byte_cnt + BYTE_W'(1);
                     r_state     <= S_START;
                     r_uart_data <= 1'b0;
                  end else begin
                     r_state     <= S_IDLE;
                     r_uart_data <= 1'b1;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CLK_W'(1);
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_uart_data <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o_uart_data = r_uart_data;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

endmodule

// File: tb/tb_conf_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_conf_uart_tx
// Directed bench for conf_uart_tx. There are two instances: one with 16 clocks
// per bit and one with 2 clocks per bit. The bench builds the expected line
// level for every cycle of a packet from the framing rules. Mid-bit samples
// are collected and compared against hand-written bit strings. The samples
// are also decoded back into parameter bytes.
// ----------------------------------------------------------------------------
module tb_conf_uart_tx;

   logic        clk;
   logic        rst;
   logic        start16, start2;
   logic [47:0] par16, par2;
   logic        uart16, busy16, done16;
   logic        uart2, busy2, done2;

   int total;
   int bad;

   localparam logic [47:0] P1 = 48'h28_4D_90_C4_FF_50;
   localparam logic [59:0] S1 =
      60'b0_00101000_1_0_01001101_1_0_10010000_1_0_11000100_1_0_11111111_1_0_01010000_1;
   localparam logic [59:0] S_ZERO =
      60'b0_00000000_1_0_00000000_1_0_00000000_1_0_00000000_1_0_00000000_1_0_00000000_1;
   localparam logic [59:0] S_ONES =
      60'b0_11111111_1_0_11111111_1_0_11111111_1_0_11111111_1_0_11111111_1_0_11111111_1;

   conf_uart_tx #(.CLKS_PER_BIT(16), .PAR_NUM(6), .PAR_WIDTH(8)) u_dut16 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start16),
      .i_par_in    (par16),
      .o_uart_data (uart16),
      .o_busy      (busy16),
      .o_done      (done16)
   );

   conf_uart_tx #(.CLKS_PER_BIT(2), .PAR_NUM(6), .PAR_WIDTH(8)) u_dut2 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start2),
      .i_par_in    (par2),
      .o_uart_data (uart2),
      .o_busy      (busy2),
      .o_done      (done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input bit sel, input string tag);
      chk({tag, " line"}, 64'(sel ? uart2 : uart16), 64'(1));
      chk({tag, " busy"}, 64'(sel ? busy2 : busy16), 64'(0));
      chk({tag, " done"}, 64'(sel ? done2 : done16), 64'(0));
   endtask

   // Entered one cycle after the accepting edge. Checks every cycle of the
   // packet, then the done cycle. Optionally pokes start/par_in mid-packet.
   task automatic run_packet(input bit sel, input logic [47:0] exp, input int cpb,
                             input int poke_at, input logic [47:0] poke_par,
                             input string tag, output logic [59:0] samp);
      int p, b, q;
      logic [7:0] eb;
      logic e;
      samp = '0;
      for (int n = 0; n < 60 * cpb; n++) begin
         p  = n / cpb;
         b  = p / 10;
         q  = p % 10;
         eb = exp[(5 - b) * 8 +: 8];
         e  = (q == 0) ? 1'b0 : (q == 9) ? 1'b1 : eb[8 - q];
         if (poke_at >= 0 && n == poke_at) begin
            start16 = 1'b1;
            par16   = poke_par;
         end else if (poke_at >= 0 && n == poke_at + 1) begin
            start16 = 1'b0;
         end
         chk({tag, " line"}, 64'(sel ? uart2 : uart16), 64'(e));
         chk({tag, " busy"}, 64'(sel ? busy2 : busy16), 64'(1));
         chk({tag, " done"}, 64'(sel ? done2 : done16), 64'(0));
         if (n % cpb == cpb / 2) samp[59 - p] = sel ? uart2 : uart16;
         tick();
      end
      chk({tag, " end done"}, 64'(sel ? done2 : done16), 64'(1));
      chk({tag, " end busy"}, 64'(sel ? busy2 : busy16), 64'(0));
      chk({tag, " end line"}, 64'(sel ? uart2 : uart16), 64'(1));
   endtask

   logic [59:0] samp;
   logic [7:0]  exp_b [6];
   logic [7:0]  rx_b;

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      start16 = 1'b0;
      start2  = 1'b0;
      par16   = '0;
      par2    = '0;
      exp_b   = '{8'h28, 8'h4D, 8'h90, 8'hC4, 8'hFF, 8'h50};

      // Reset state
      tick(); tick(); tick();
      chk_idle(1'b0, "rst16");
      chk_idle(1'b1, "rst2");
      rst = 1'b0;
      tick();
      chk_idle(1'b0, "post rst16");

      // Test 1: single packet, 960 busy cycles, done on cycle 961
      par16   = P1;
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      run_packet(1'b0, P1, 16, -1, '0, "t1", samp);
      chk("t1 bits", 64'(samp), 64'(S1));
      tick();
      chk_idle(1'b0, "t1 after done");

      // Test 2: receiver-side decode of the mid-bit samples
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 8; k++) rx_b[7 - k] = samp[58 - 10 * i - k];
         chk($sformatf("t2 byte%0d", i), 64'(rx_b), 64'(exp_b[i]));
         chk($sformatf("t2 stop%0d", i), 64'(samp[50 - 10 * i]), 64'(1));
      end

      // Test 3: start and par_in changes mid-packet are ignored
      tick(); tick();
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      run_packet(1'b0, P1, 16, 100, 48'h11_22_33_44_55_66, "t3", samp);
      chk("t3 bits", 64'(samp), 64'(S1));
      tick();
      chk_idle(1'b0, "t3 single done");

      // Test 4: start held high gives back-to-back packets, one idle cycle apart
      par16   = P1;
      start16 = 1'b1;
      tick();
      for (int r = 0; r < 3; r++) begin
         run_packet(1'b0, P1, 16, -1, '0, $sformatf("t4 pkt%0d", r), samp);
         chk($sformatf("t4 bits%0d", r), 64'(samp), 64'(S1));
         if (r == 2) start16 = 1'b0;
         tick();
      end
      chk_idle(1'b0, "t4 stop");

      // Test 5: reset during DATA of byte 3 aborts the packet
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      for (int n = 0; n < 536; n++) tick();
      chk("t5 pre line", 64'(uart16), 64'(0));
      chk("t5 pre busy", 64'(busy16), 64'(1));
      rst = 1'b1;
      tick();
      chk_idle(1'b0, "t5 rst");
      rst = 1'b0;
      tick();
      chk_idle(1'b0, "t5 post");
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      run_packet(1'b0, P1, 16, -1, '0, "t5 full", samp);
      chk("t5 bits", 64'(samp), 64'(S1));
      tick();

      // Test 6: two clocks per bit, all zeros then all ones
      par2   = 48'h00_00_00_00_00_00;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      run_packet(1'b1, par2, 2, -1, '0, "t6 zero", samp);
      chk("t6 zero bits", 64'(samp), 64'(S_ZERO));
      tick();
      chk_idle(1'b1, "t6 gap");
      par2   = 48'hFF_FF_FF_FF_FF_FF;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      run_packet(1'b1, par2, 2, -1, '0, "t6 ones", samp);
      chk("t6 ones bits", 64'(samp), 64'(S_ONES));
      tick();
      chk_idle(1'b1, "t6 end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
